// File: rtl/bullet_collider.sv
// bullet_collider: watches the scan-out pixel stream for bullet/asteroid/ship
// overlaps, then at each frame tick commits per-slot reset levels, a sticky
// ship-hit flag and a saturating score.
module bullet_collider #(
   parameter int NB      = 4,
   parameter int NA      = 8,
   parameter int SCORE_W = 16,
   parameter int HIT_PTS = 10,
   parameter int H_VIS   = 640,
   parameter int V_VIS   = 480
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         px,
   input  logic [9:0]         py,
   input  logic               frame_tick,
   input  logic [NB-1:0]      bullet_pixel,
   input  logic [NA-1:0]      rock_pixel,
   input  logic               ship_pixel,
   input  logic               clear_game,
   output logic [NB-1:0]      bullet_reset,
   output logic [NA-1:0]      rock_reset,
   output logic               ship_hit,
   output logic [SCORE_W-1:0] score,
   output logic               busy
);

   localparam int KW = (NA > 1) ? $clog2(NA) : 1;
   localparam logic [9:0]         HV  = 10'(H_VIS);
   localparam logic [9:0]         VV  = 10'(V_VIS);
   localparam logic [SCORE_W:0]   PTS = (SCORE_W+1)'(HIT_PTS);
   localparam logic [KW-1:0]      KLAST = KW'(NA-1);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT, SCORE} state_t;

   state_t               state_q, state_d;
   logic [NB-1:0]        bacc_q, bacc_d, breset_q, breset_d;
   logic [NA-1:0]        racc_q, racc_d, rreset_q, rreset_d, rq_q, rq_d;
   logic                 sacc_q, sacc_d, ship_q, ship_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [KW-1:0]        k_q, k_d;

   logic                 visible;
   logic [NB-1:0]        bnew;
   logic [NA-1:0]        rnew;
   logic                 snew;

   // Add one hit's worth of points, clamping at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + PTS;
      if (sum[SCORE_W]) return '1;
      return sum[SCORE_W-1:0];
   endfunction

   // Per-pixel overlap terms; off-screen pixels never count.
   always_comb begin
      visible = (px < HV) && (py < VV);
      bnew    = '0;
      rnew    = '0;
      snew    = 1'b0;
      if (visible) begin
         bnew = bullet_pixel & {NB{|rock_pixel}};
         rnew = rock_pixel & {NA{|bullet_pixel}};
         snew = ship_pixel & (|rock_pixel);
      end
   end

   // Next-state and commit/score logic; clear_game overrides score and ship_hit last.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      bacc_d   = bacc_q | bnew;
      racc_d   = racc_q | rnew;
      sacc_d   = sacc_q | snew;
      breset_d = breset_q;
      rreset_d = rreset_q;
      rq_d     = rq_q;
      ship_d   = ship_q;
      score_d  = score_q;
      case (state_q)
         IDLE: begin
            // Partial first frame is discarded.
            bacc_d = '0;
            racc_d = '0;
            sacc_d = 1'b0;
            if (frame_tick) state_d = SCAN;
         end
         SCAN: begin
            if (frame_tick) state_d = COMMIT;
         end
         COMMIT: begin
            breset_d = bacc_q;
            rreset_d = racc_q;
            ship_d   = ship_q | sacc_q;
            rq_d     = racc_q;
            // Accumulators restart with this cycle's overlap so it is not lost.
            bacc_d   = bnew;
            racc_d   = rnew;
            sacc_d   = snew;
            k_d      = '0;
            state_d  = SCORE;
         end
         SCORE: begin
            if (rq_q[k_q]) score_d = sat_add(score_q);
            if (k_q == KLAST) state_d = SCAN;
            else              k_d = k_q + KW'(1);
         end
         default: state_d = IDLE;
      endcase
      if (clear_game) begin
         score_d = '0;
         ship_d  = 1'b0;
      end
   end

   // State and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         bacc_q   <= '0;
         racc_q   <= '0;
         sacc_q   <= 1'b0;
         breset_q <= '0;
         rreset_q <= '0;
         rq_q     <= '0;
         ship_q   <= 1'b0;
         score_q  <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         bacc_q   <= bacc_d;
         racc_q   <= racc_d;
         sacc_q   <= sacc_d;
         breset_q <= breset_d;
         rreset_q <= rreset_d;
         rq_q     <= rq_d;
         ship_q   <= ship_d;
         score_q  <= score_d;
      end
   end

   assign bullet_reset = breset_q;
   assign rock_reset   = rreset_q;
   assign ship_hit     = ship_q;
   assign score        = score_q;
   assign busy         = (state_q == COMMIT) || (state_q == SCORE);

endmodule

// File: tb/tb_bullet_collider.sv
// Directed bench for bullet_collider: a default instance plus a 6-bit-score
// instance sharing the same stimulus for the saturation case.
module tb_bullet_collider;

   localparam int NB = 4;
   localparam int NA = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [9:0]    px, py;
   logic          frame_tick;
   logic [NB-1:0] bullet_pixel;
   logic [NA-1:0] rock_pixel;
   logic          ship_pixel;
   logic          clear_game;

   logic [NB-1:0] bullet_reset, bullet_reset_s;
   logic [NA-1:0] rock_reset, rock_reset_s;
   logic          ship_hit, ship_hit_s;
   logic [15:0]   score;
   logic [5:0]    score_s;
   logic          busy, busy_s;

   int total = 0;
   int bad   = 0;
   int bcnt;

   bullet_collider #(.NB(NB), .NA(NA), .SCORE_W(16)) dut (
      .clk(clk), .reset(reset), .px(px), .py(py), .frame_tick(frame_tick),
      .bullet_pixel(bullet_pixel), .rock_pixel(rock_pixel), .ship_pixel(ship_pixel),
      .clear_game(clear_game), .bullet_reset(bullet_reset), .rock_reset(rock_reset),
      .ship_hit(ship_hit), .score(score), .busy(busy)
   );

   bullet_collider #(.NB(NB), .NA(NA), .SCORE_W(6)) dut_sat (
      .clk(clk), .reset(reset), .px(px), .py(py), .frame_tick(frame_tick),
      .bullet_pixel(bullet_pixel), .rock_pixel(rock_pixel), .ship_pixel(ship_pixel),
      .clear_game(clear_game), .bullet_reset(bullet_reset_s), .rock_reset(rock_reset_s),
      .ship_hit(ship_hit_s), .score(score_s), .busy(busy_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hit(input logic [9:0] x, input logic [9:0] y, input logic [NB-1:0] b,
                      input logic [NA-1:0] r, input logic s, input int n);
      px = x; py = y; bullet_pixel = b; rock_pixel = r; ship_pixel = s;
      step(n);
      bullet_pixel = '0; rock_pixel = '0; ship_pixel = 1'b0; px = 10'd0; py = 10'd0;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; px = '0; py = '0; frame_tick = 1'b0;
      bullet_pixel = '0; rock_pixel = '0; ship_pixel = 1'b0; clear_game = 1'b0;
      step(2);
      chk("rst_breset", 32'(bullet_reset), 0);
      chk("rst_rreset", 32'(rock_reset), 0);
      chk("rst_ship", 32'(ship_hit), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b1;
      step(1);

      // IDLE and off-screen overlaps must not count
      hit(10'd10, 10'd10, 4'b0010, 8'h04, 1'b0, 3);
      frame();
      hit(10'd700, 10'd100, 4'b0010, 8'h04, 1'b0, 3);
      hit(10'd100, 10'd480, 4'b0001, 8'h01, 1'b0, 2);
      frame();
      chk("filt_busy_commit", 32'(busy), 1);
      step(1);
      chk("filt_breset", 32'(bullet_reset), 0);
      chk("filt_rreset", 32'(rock_reset), 0);
      step(NA);
      chk("filt_score", 32'(score), 0);
      chk("filt_busy_done", 32'(busy), 0);

      // basic hit
      hit(10'd100, 10'd200, 4'b0010, 8'h04, 1'b0, 3);
      frame();
      step(1);
      chk("basic_breset", 32'(bullet_reset), 32'h2);
      chk("basic_rreset", 32'(rock_reset), 32'h04);
      chk("basic_score_early", 32'(score), 0);
      step(NA);
      chk("basic_score", 32'(score), 10);
      step(5);
      chk("basic_hold_b", 32'(bullet_reset), 32'h2);
      chk("basic_hold_r", 32'(rock_reset), 32'h04);
      frame();
      step(1);
      chk("basic_clr_b", 32'(bullet_reset), 0);
      chk("basic_clr_r", 32'(rock_reset), 0);
      step(NA);
      chk("basic_score_keep", 32'(score), 10);

      // multi-overlap: bullets 0,3 on rock 5; bullet 1 on rocks 0,1
      hit(10'd50, 10'd60, 4'b1001, 8'h20, 1'b0, 2);
      hit(10'd300, 10'd400, 4'b0010, 8'h03, 1'b0, 1);
      frame();
      step(1);
      chk("multi_breset", 32'(bullet_reset), 32'hb);
      chk("multi_rreset", 32'(rock_reset), 32'h23);
      step(NA);
      chk("multi_score", 32'(score), 40);
      chk("multi_score_s", 32'(score_s), 40);

      // saturation: restart, six single-hit frames, then two more
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      frame();
      for (int f = 0; f < 6; f++) begin
         hit(10'd100, 10'd100, 4'b0001, 8'h01, 1'b0, 1);
         frame();
         step(1 + NA);
      end
      chk("sat_pre", 32'(score), 60);
      chk("sat_pre_s", 32'(score_s), 60);
      hit(10'd100, 10'd100, 4'b0001, 8'h01, 1'b0, 1);
      frame();
      step(1 + NA);
      chk("sat_main70", 32'(score), 70);
      chk("sat_s63", 32'(score_s), 63);
      hit(10'd100, 10'd100, 4'b0001, 8'h01, 1'b0, 1);
      frame();
      step(1 + NA);
      chk("sat_main80", 32'(score), 80);
      chk("sat_s63_hold", 32'(score_s), 63);

      // ship hit, sticky over three frames
      hit(10'd320, 10'd240, 4'b0000, 8'h01, 1'b1, 2);
      frame();
      step(1);
      chk("ship_set", 32'(ship_hit), 1);
      chk("ship_no_rock", 32'(rock_reset), 0);
      step(NA);
      for (int f = 0; f < 3; f++) begin
         frame();
         step(1 + NA);
         chk("ship_sticky", 32'(ship_hit), 1);
      end
      chk("ship_score", 32'(score), 80);

      // clear_game on the same cycle as the k=2 score add
      hit(10'd5, 10'd5, 4'b0001, 8'h04, 1'b0, 1);
      frame();
      step(3);
      clear_game = 1'b1;
      step(1);
      clear_game = 1'b0;
      chk("clr_score", 32'(score), 0);
      chk("clr_score_s", 32'(score_s), 0);
      chk("clr_ship", 32'(ship_hit), 0);
      chk("clr_rreset_kept", 32'(rock_reset), 32'h04);
      step(NA - 3);
      chk("clr_score_after", 32'(score), 0);

      // frame_tick while busy is ignored
      hit(10'd5, 10'd5, 4'b0001, 8'h01, 1'b0, 1);
      frame();
      bcnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (busy) bcnt++;
         frame_tick = (c == 2);
         step(1);
      end
      frame_tick = 1'b0;
      chk("busy_len", 32'(bcnt), NA + 1);
      chk("busy_tick_r", 32'(rock_reset), 32'h01);
      chk("busy_tick_b", 32'(bullet_reset), 32'h1);
      chk("busy_tick_score", 32'(score), 10);

      // reset during SCORE at k=3
      hit(10'd5, 10'd5, 4'b0001, 8'h01, 1'b1, 1);
      frame();
      step(4);
      chk("mid_busy_pre", 32'(busy), 1);
      chk("mid_ship_pre", 32'(ship_hit), 1);
      chk("mid_score_pre", 32'(score), 20);
      reset = 1'b0;
      #1;
      chk("mid_score", 32'(score), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_ship", 32'(ship_hit), 0);
      chk("mid_breset", 32'(bullet_reset), 0);
      chk("mid_rreset", 32'(rock_reset), 0);
      step(1);
      reset = 1'b1;
      hit(10'd5, 10'd5, 4'b0001, 8'h01, 1'b0, 2);
      frame();
      chk("post_idle_busy", 32'(busy), 0);
      step(2);
      chk("post_idle_b", 32'(bullet_reset), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
